// File: rtl/usb_fs_tx_serializer.sv
// USB full-speed transmit bit engine: SYNC, LSB-first data with bit stuffing
// and NRZI, then EOP, all timed from the reference clock.
module usb_fs_tx_serializer #(
    parameter int REF_CLK_FREQ = 48_000_000,
    parameter int USB_BIT_RATE = 12_000_000,
    parameter int STUFF_RUN    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_dp,
    output logic       tx_dn,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       tx_underrun
);
    localparam int BIT_PERIOD_TICKS = REF_CLK_FREQ / USB_BIT_RATE;
    localparam int TW = (BIT_PERIOD_TICKS > 1) ? $clog2(BIT_PERIOD_TICKS) : 1;
    localparam int OW = $clog2(STUFF_RUN + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } state_t;

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic [OW-1:0] r_ones, w_ones_next;
    logic [2:0]    r_bitcnt, w_bitcnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_last, w_last_next;
    logic          r_lvl, w_lvl_next;
    logic          r_eop_cnt, w_eop_cnt_next;
    logic          r_dp, w_dp_next;
    logic          r_dn, w_dn_next;
    logic          r_oe, w_oe_next;

    logic          w_bound;
    logic          w_stuff_due;
    logic          w_byte_end;
    logic          w_need_byte;
    logic          w_emit;
    logic          w_bit;
    logic [2:0]    w_nxt_idx;

    // A bit time ends when the timer reaches its last tick.
    assign w_bound     = (r_timer == TW'(BIT_PERIOD_TICKS - 1));
    assign w_stuff_due = (r_ones == OW'(STUFF_RUN));
    // Byte-end boundary of SYNC or a data byte, after any pending stuff bit.
    assign w_byte_end  = ((r_state == SYNC) || (r_state == DATA)) && w_bound &&
                         !w_stuff_due && (r_bitcnt == 3'd7);
    assign w_need_byte = w_byte_end && !r_last;
    assign w_nxt_idx   = r_bitcnt + 3'd1;

    assign tx_ready    = w_need_byte && tx_valid;
    assign tx_underrun = w_need_byte && !tx_valid;
    assign tx_dp       = r_dp;
    assign tx_dn       = r_dn;
    assign tx_oe       = r_oe;
    assign tx_busy     = r_oe;

    // Next-state logic: sequencing, byte loading, stuffing and NRZI encoding.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_ones_next    = r_ones;
        w_bitcnt_next  = r_bitcnt;
        w_shift_next   = r_shift;
        w_last_next    = r_last;
        w_lvl_next     = r_lvl;
        w_eop_cnt_next = r_eop_cnt;
        w_dp_next      = r_dp;
        w_dn_next      = r_dn;
        w_oe_next      = r_oe;
        w_emit         = 1'b0;
        w_bit          = 1'b0;

        if (r_state != IDLE) begin
            w_timer_next = w_bound ? '0 : r_timer + TW'(1);
        end

        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    // First SYNC bit is a 0: line goes from J to K right away.
                    w_state_next  = SYNC;
                    w_timer_next  = '0;
                    w_bitcnt_next = 3'd0;
                    w_ones_next   = '0;
                    w_last_next   = 1'b0;
                    w_lvl_next    = 1'b0;
                    w_dp_next     = 1'b0;
                    w_dn_next     = 1'b1;
                    w_oe_next     = 1'b1;
                end
            end
            SYNC, DATA: begin
                if (w_bound) begin
                    if (w_stuff_due) begin
                        // Stuffed 0; the data bit position does not advance.
                        w_emit = 1'b1;
                        w_bit  = 1'b0;
                    end else if (r_bitcnt != 3'd7) begin
                        w_bitcnt_next = w_nxt_idx;
                        w_emit        = 1'b1;
                        w_bit         = (r_state == SYNC) ? (w_nxt_idx == 3'd7)
                                                          : r_shift[w_nxt_idx];
                    end else if (r_last || !tx_valid) begin
                        w_state_next   = EOP_SE0;
                        w_eop_cnt_next = 1'b0;
                        w_dp_next      = 1'b0;
                        w_dn_next      = 1'b0;
                    end else begin
                        w_state_next  = DATA;
                        w_shift_next  = tx_data;
                        w_last_next   = tx_last;
                        w_bitcnt_next = 3'd0;
                        w_emit        = 1'b1;
                        w_bit         = tx_data[0];
                    end
                end
            end
            EOP_SE0: begin
                if (w_bound) begin
                    if (!r_eop_cnt) begin
                        w_eop_cnt_next = 1'b1;
                    end else begin
                        w_state_next = EOP_J;
                        w_dp_next    = 1'b1;
                        w_dn_next    = 1'b0;
                    end
                end
            end
            EOP_J: begin
                if (w_bound) begin
                    w_state_next = IDLE;
                    w_timer_next = '0;
                    w_oe_next    = 1'b0;
                    w_dp_next    = 1'b1;
                    w_dn_next    = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_oe_next    = 1'b0;
                w_dp_next    = 1'b1;
                w_dn_next    = 1'b0;
            end
        endcase

        if (w_emit) begin
            // NRZI: 0 toggles the level, 1 holds it and extends the ones run.
            w_lvl_next  = w_bit ? r_lvl : ~r_lvl;
            w_ones_next = w_bit ? OW'(r_ones + OW'(1)) : '0;
            w_dp_next   = w_lvl_next;
            w_dn_next   = ~w_lvl_next;
        end
    end

    // State and line registers; reset forces idle J with the driver off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_ones    <= '0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_last    <= 1'b0;
            r_lvl     <= 1'b1;
            r_eop_cnt <= 1'b0;
            r_dp      <= 1'b1;
            r_dn      <= 1'b0;
            r_oe      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_ones    <= w_ones_next;
            r_bitcnt  <= w_bitcnt_next;
            r_shift   <= w_shift_next;
            r_last    <= w_last_next;
            r_lvl     <= w_lvl_next;
            r_eop_cnt <= w_eop_cnt_next;
            r_dp      <= w_dp_next;
            r_dn      <= w_dn_next;
            r_oe      <= w_oe_next;
        end
    end
endmodule
